// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line and baud select in, recovered byte and status pulses out.
interface uart_rx_if;
    logic [1:0] baud_sel;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       busy;

    modport master (
        output baud_sel,
        output rx,
        input  data_out,
        input  data_valid,
        input  framing_err,
        input  busy
    );

    modport slave (
        input  baud_sel,
        input  rx,
        output data_out,
        output data_valid,
        output framing_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. The start bit is confirmed at its
// midpoint; every later bit is sampled 16 ticks after the previous sample.
// Results appear as a registered 1-cycle data_valid or framing_err pulse.
module uart_rx #(
    parameter int FREQ       = 50_000_000,
    parameter int BAUD_2400  = 2400,
    parameter int BAUD_4800  = 4800,
    parameter int BAUD_9600  = 9600,
    parameter int BAUD_19200 = 19200
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);

    localparam logic [15:0] DIV_2400  = 16'(FREQ / (16 * BAUD_2400));
    localparam logic [15:0] DIV_4800  = 16'(FREQ / (16 * BAUD_4800));
    localparam logic [15:0] DIV_9600  = 16'(FREQ / (16 * BAUD_9600));
    localparam logic [15:0] DIV_19200 = 16'(FREQ / (16 * BAUD_19200));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Tick divisor for a given baud select code.
    function automatic logic [15:0] div_for(input logic [1:0] sel);
        logic [15:0] div;
        case (sel)
            2'b00:   div = DIV_2400;
            2'b01:   div = DIV_4800;
            2'b10:   div = DIV_9600;
            default: div = DIV_19200;
        endcase
        return div;
    endfunction

    state_t      state_q, state_d;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic        rx_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        framing_err_q, framing_err_d;
    logic        busy_q, busy_d;
    logic        tick;

    // Next-state logic: oversampling counter, bit sampling and frame decisions.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        tick_cnt_d    = tick_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        framing_err_d = 1'b0;

        tick = (cnt_q == div_q - 16'd1);
        if (state_q != IDLE) begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = START;
                    tick_cnt_d = 4'd0;
                    div_d      = div_for(bus.baud_sel);
                end
            end
            START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd7) begin
                        // Midpoint of the start bit: a high line here was a glitch.
                        if (!rx_s_q) begin
                            state_d    = DATA;
                            tick_cnt_d = 4'd0;
                            bit_idx_d  = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d[bit_idx_q] = rx_s_q;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        if (rx_s_q) begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                        end else begin
                            framing_err_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; the synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            cnt_q         <= 16'd0;
            div_q         <= 16'd0;
            tick_cnt_q    <= 4'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= bus.rx;
            rx_s_q        <= rx_meta_q;
            rx_prev_q     <= rx_s_q;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.framing_err = framing_err_q;
    assign bus.busy        = busy_q;

endmodule
